// File: rtl/audio_pkg.sv
// Shared types and constants for the audio FIR stage: default widths, coefficient
// tables, FSM encoding and a saturation helper.
package audio_pkg;
    localparam int DATA_W_DEF = 24;
    localparam int COEF_W_DEF = 16;
    localparam int NUM_CH     = 2;

    typedef logic signed [15:0] coef_t;

    // Symmetric 16-tap low-pass; taps sum to 32768 so DC gain is exactly one.
    localparam coef_t COEF_LP [0:63] = '{
        0: 16'sd128,   1: 16'sd384,   2: 16'sd768,   3: 16'sd1280,
        4: 16'sd1920,  5: 16'sd2688,  6: 16'sd3584,  7: 16'sd5632,
        8: 16'sd5632,  9: 16'sd3584, 10: 16'sd2688, 11: 16'sd1920,
       12: 16'sd1280, 13: 16'sd768,  14: 16'sd384,  15: 16'sd128,
        default: 16'sd0
    };

    localparam coef_t COEF_STRESS [0:63] = '{default: 16'sd32767};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MAC     = 2'd1;
    localparam logic [1:0] S_ROUND   = 2'd2;
    localparam logic [1:0] S_WAIT_WR = 2'd3;

    function automatic coef_t coef(input int sel, input int k);
        return (sel == 1) ? COEF_STRESS[k[5:0]] : COEF_LP[k[5:0]];
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction
endpackage

// File: rtl/fir_delay_line.sv
// Per-channel circular sample buffer: one synchronous write port, one
// combinational read port, bulk clear.
module fir_delay_line #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/audio_mac_fir.sv
// Time-multiplexed stereo FIR between codec read and write ports: pop a pair,
// TAPS cycles of MAC on both channels, round/saturate, push under handshake.
module audio_mac_fir
    import audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int COEF_FRAC = 15,
    parameter int TAPS      = 16,
    parameter int COEF_SEL  = 0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              sat
);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC - 1);

    logic [1:0]       state;
    logic [TAP_W-1:0] ptr, newest, k, rd_idx;
    logic             rst_d, pop;
    logic signed [COEF_W-1:0] coef_k;

    logic [NUM_CH-1:0][DATA_W-1:0] din, tap, rnd_sat, wdat;
    logic [NUM_CH-1:0][PROD_W-1:0] prod;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc;
    logic [NUM_CH-1:0]             clip;

    // rst_d keeps the pop masked for the first cycle after reset releases.
    assign pop    = (state == S_IDLE) && read_ready && !reset && !rst_d;
    assign read   = pop;
    assign write  = (state == S_WAIT_WR) && write_ready && !reset;
    assign busy   = (state != S_IDLE) && !reset;
    assign rd_idx = newest - k;
    assign coef_k = COEF_W'(coef(COEF_SEL, int'(k)));

    assign din[0]          = readdata_left;
    assign din[1]          = readdata_right;
    assign writedata_left  = wdat[0];
    assign writedata_right = wdat[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [ACC_W-1:0] rnd;
        logic signed [63:0]      sat_v;

        fir_delay_line #(.DATA_W(DATA_W), .DEPTH(TAPS)) u_dl (
            .clk   (CLOCK_50),
            .clr   (reset),
            .we    (pop),
            .waddr (ptr),
            .wdata (din[c]),
            .raddr (rd_idx),
            .rdata (tap[c])
        );

        assign prod[c]    = $signed(tap[c]) * coef_k;
        assign rnd        = ($signed(acc[c]) + $signed(HALF)) >>> COEF_FRAC;
        assign sat_v      = saturate(64'(rnd), DATA_W);
        assign clip[c]    = (sat_v != 64'(rnd));
        assign rnd_sat[c] = sat_v[DATA_W-1:0];
    end

    always_ff @(posedge CLOCK_50) begin
        rst_d <= reset;
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            newest <= '0;
            k      <= '0;
            acc    <= '0;
            wdat   <= '0;
            sat    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    newest <= ptr;
                    ptr    <= ptr + TAP_W'(1);
                    acc    <= '0;
                    k      <= '0;
                    state  <= S_MAC;
                end
                S_MAC: begin
                    for (int c = 0; c < NUM_CH; c++)
                        acc[c] <= ACC_W'($signed(acc[c]) + $signed(prod[c]));
                    k <= k + TAP_W'(1);
                    if (k == TAP_W'(TAPS - 1)) state <= S_ROUND;
                end
                S_ROUND: begin
                    wdat  <= rnd_sat;
                    if (|clip) sat <= 1'b1;
                    state <= S_WAIT_WR;
                end
                S_WAIT_WR: if (write_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
